// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the shared RV32 datapath.
// The sequencer holds the master side; the datapath (or a bench) holds the slave side.
interface multicycle_control_fsm_if #(
  parameter int OPW = 7,
  parameter int STW = 4
);
  logic [OPW-1:0] op;
  logic           zero;
  logic           mem_ready;
  logic           pc_write;
  logic           adr_src;
  logic           mem_write;
  logic           ir_write;
  logic           reg_write;
  logic [1:0]     result_src;
  logic [1:0]     alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic           instr_done;
  logic           illegal_op;
  logic [STW-1:0] state;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, instr_done, illegal_op, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequencer for the RV32 multicycle core: steps fetch/decode/execute/memory/writeback
// and drives the datapath controls, with a memory-ready handshake and illegal-opcode halt.
module multicycle_control_fsm #(
  parameter int OPW = 7,
  parameter int STW = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_fsm_if.master   ctl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_e;

  localparam logic [OPW-1:0] OP_LOAD   = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_OPIMM  = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_OP     = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_BRANCH = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_JAL    = OPW'(7'b1101111);

  state_e     state_q, state_d;
  logic       fetch_q, beq_q, memwr_q, pcw_q, regw_q, done_q, adr_q, ill_q;
  logic [1:0] rs_q, a_q, b_q, alu_q;

  always_comb begin
    state_d = S_FETCH;
    if (!reset) begin
      unique case (state_q)
        S_FETCH:    state_d = ctl.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (ctl.op == OP_LOAD || ctl.op == OP_STORE) state_d = S_MEMADR;
          else if (ctl.op == OP_OP)                    state_d = S_EXECR;
          else if (ctl.op == OP_OPIMM)                 state_d = S_EXECI;
          else if (ctl.op == OP_BRANCH)                state_d = S_BEQ;
          else if (ctl.op == OP_JAL)                   state_d = S_JAL;
          else                                         state_d = S_ILLEGAL;
        end
        // op is stable from DECODE, so only LOAD/STORE can arrive here
        S_MEMADR:   state_d = (ctl.op == OP_LOAD)  ? S_MEMREAD  :
                              (ctl.op == OP_STORE) ? S_MEMWRITE : S_ILLEGAL;
        S_MEMREAD:  state_d = ctl.mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state_d = S_FETCH;
        S_MEMWRITE: state_d = ctl.mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state_d = S_ALUWB;
        S_EXECI:    state_d = S_ALUWB;
        S_ALUWB:    state_d = S_FETCH;
        S_BEQ:      state_d = S_FETCH;
        S_JAL:      state_d = S_ALUWB;
        S_ILLEGAL:  state_d = S_ILLEGAL;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  // Moore controls are decoded from the next state so they arrive registered with it
  always_ff @(posedge clk) begin
    state_q <= state_d;
    fetch_q <= (state_d == S_FETCH);
    beq_q   <= (state_d == S_BEQ);
    memwr_q <= (state_d == S_MEMWRITE);
    pcw_q   <= (state_d == S_JAL);
    regw_q  <= (state_d == S_MEMWB) || (state_d == S_ALUWB);
    done_q  <= (state_d == S_MEMWB) || (state_d == S_ALUWB) || (state_d == S_BEQ);
    adr_q   <= (state_d == S_MEMREAD) || (state_d == S_MEMWRITE);
    ill_q   <= reset ? 1'b0 : (ill_q || (state_d == S_ILLEGAL));
    rs_q    <= 2'b00;
    a_q     <= 2'b00;
    b_q     <= 2'b00;
    alu_q   <= 2'b00;
    unique case (state_d)
      S_FETCH:  begin rs_q <= 2'b10; b_q <= 2'b10; end
      S_DECODE: begin a_q <= 2'b01; b_q <= 2'b01; end
      S_MEMADR: begin a_q <= 2'b10; b_q <= 2'b01; end
      S_MEMWB:  rs_q <= 2'b01;
      S_EXECR:  begin a_q <= 2'b10; alu_q <= 2'b10; end
      S_EXECI:  begin a_q <= 2'b10; b_q <= 2'b01; alu_q <= 2'b10; end
      S_BEQ:    begin a_q <= 2'b10; alu_q <= 2'b01; end
      S_JAL:    begin a_q <= 2'b01; b_q <= 2'b10; end
      default:  ;
    endcase
  end

  // Reset must quiet the enables and show FETCH immediately, even mid-instruction
  assign ctl.pc_write   = !reset && (pcw_q || (fetch_q && ctl.mem_ready) || (beq_q && ctl.zero));
  assign ctl.ir_write   = !reset && fetch_q && ctl.mem_ready;
  assign ctl.mem_write  = !reset && memwr_q;
  assign ctl.reg_write  = !reset && regw_q;
  assign ctl.instr_done = !reset && (done_q || (memwr_q && ctl.mem_ready));
  assign ctl.adr_src    = !reset && adr_q;
  assign ctl.result_src = reset ? 2'b10 : rs_q;
  assign ctl.alu_src_a  = reset ? 2'b00 : a_q;
  assign ctl.alu_src_b  = reset ? 2'b10 : b_q;
  assign ctl.alu_op     = reset ? 2'b00 : alu_q;
  assign ctl.illegal_op = ill_q;
  assign ctl.state      = reset ? '0 : STW'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected traces built from the
// opcode's state path and random memory wait counts, compared cycle by cycle.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.OPW(7), .STW(4)) ctl ();
  multicycle_control_fsm #(.OPW(7), .STW(4)) dut (.clk(clk), .reset(reset), .ctl(ctl));

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011;
  localparam logic [6:0] OPR  = 7'b0110011, BR    = 7'b1100011, JAL   = 7'b1101111;

  int total = 0;
  int bad   = 0;
  int         st_q[$];
  logic       mr_q[$];
  logic       z_q[$];
  logic [6:0] op_q[$];

  // {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, alu_op, instr_done, illegal_op}
  function automatic logic [18:0] exp_vec(input int st, input logic mr, input logic z);
    logic pcw, adr, mw, irw, rw, dn, il;
    logic [1:0] rs, a, b, alu;
    {pcw, adr, mw, irw, rw, dn, il} = '0;
    {rs, a, b, alu} = '0;
    case (st)
      0:  begin rs = 2'b10; b = 2'b10; irw = mr; pcw = mr; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; dn = mr; end
      6:  begin a = 2'b10; alu = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      8:  begin rw = 1'b1; dn = 1'b1; end
      9:  begin a = 2'b10; alu = 2'b01; pcw = z; dn = 1'b1; end
      10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      15: il = 1'b1;
      default: ;
    endcase
    return {4'(st), pcw, adr, mw, irw, rw, rs, a, b, alu, dn, il};
  endfunction

  function automatic logic [18:0] observed();
    return {ctl.state, ctl.pc_write, ctl.adr_src, ctl.mem_write, ctl.ir_write, ctl.reg_write,
            ctl.result_src, ctl.alu_src_a, ctl.alu_src_b, ctl.alu_op, ctl.instr_done, ctl.illegal_op};
  endfunction

  task automatic step(input logic rst_v, input logic mr, input logic z, input logic [6:0] opv,
                      output logic [18:0] obs);
    reset = rst_v; ctl.mem_ready = mr; ctl.zero = z; ctl.op = opv;
    @(negedge clk);
    obs = observed();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int st, input logic mr, input logic z, input logic [6:0] opv);
    st_q.push_back(st); mr_q.push_back(mr); z_q.push_back(z); op_q.push_back(opv);
  endtask

  // Expected trace of one instruction: state path from the opcode, waits where memory stalls
  task automatic build(input logic [6:0] opv, input logic zv, input int wf, input int wm, input int ill_n);
    for (int i = 0; i < wf; i++) push(0, 1'b0, 1'($urandom), 7'($urandom));
    push(0, 1'b1, 1'($urandom), 7'($urandom));
    push(1, 1'($urandom), 1'($urandom), opv);
    case (opv)
      LOAD: begin
        push(2, 1'($urandom), 1'($urandom), opv);
        for (int i = 0; i < wm; i++) push(3, 1'b0, 1'($urandom), opv);
        push(3, 1'b1, 1'($urandom), opv);
        push(4, 1'($urandom), 1'($urandom), opv);
      end
      STORE: begin
        push(2, 1'($urandom), 1'($urandom), opv);
        for (int i = 0; i < wm; i++) push(5, 1'b0, 1'($urandom), opv);
        push(5, 1'b1, 1'($urandom), opv);
      end
      OPR:   begin push(6, 1'($urandom), 1'($urandom), opv); push(8, 1'($urandom), 1'($urandom), opv); end
      OPIMM: begin push(7, 1'($urandom), 1'($urandom), opv); push(8, 1'($urandom), 1'($urandom), opv); end
      BR:    push(9, 1'($urandom), zv, opv);
      JAL:   begin push(10, 1'($urandom), 1'($urandom), opv); push(8, 1'($urandom), 1'($urandom), opv); end
      default: for (int i = 0; i < ill_n; i++) push(15, 1'($urandom), 1'($urandom), 7'($urandom));
    endcase
  endtask

  task automatic clear_q();
    st_q.delete(); mr_q.delete(); z_q.delete(); op_q.delete();
  endtask

  task automatic test_reset();
    logic [18:0] obs, exp;
    exp = exp_vec(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 7'($urandom), obs);
      total++;
      if (obs[18:1] !== exp[18:1]) begin
        bad++; $display("FAIL reset[%0d] got=%h want=%h", i, obs, exp);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [18:0] obs, exp;
    clear_q(); build(LOAD, 1'b0, 0, 0, 0);
    total++;
    if (st_q.size() !== 5) begin bad++; $display("FAIL load_len got=%0d want=5", st_q.size()); end
    for (int i = 0; i < st_q.size(); i++) begin
      step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
      exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL load[%0d] got=%h want=%h", i, obs, exp); end
    end
  endtask

  task automatic test_store_wait();
    logic [18:0] obs, exp;
    int mw_cnt = 0;
    clear_q(); build(STORE, 1'b0, 0, 3, 0);
    for (int i = 0; i < st_q.size(); i++) begin
      step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
      exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
      if (obs[12]) mw_cnt++;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL store[%0d] got=%h want=%h", i, obs, exp); end
    end
    total++;
    if (mw_cnt !== 4) begin bad++; $display("FAIL store_mw_cycles got=%0d want=4", mw_cnt); end
  endtask

  task automatic test_branch();
    logic [18:0] obs, exp;
    for (int zz = 1; zz >= 0; zz--) begin
      clear_q(); build(BR, 1'(zz), 0, 0, 0);
      for (int i = 0; i < st_q.size(); i++) begin
        step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
        exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL beq_z%0d[%0d] got=%h want=%h", zz, i, obs, exp); end
      end
    end
  endtask

  task automatic test_jal_exec();
    logic [18:0] obs, exp;
    logic [6:0] ops [3];
    ops[0] = JAL; ops[1] = OPIMM; ops[2] = OPR;
    for (int k = 0; k < 3; k++) begin
      clear_q(); build(ops[k], 1'b0, 0, 0, 0);
      for (int i = 0; i < st_q.size(); i++) begin
        step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
        exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL op%b[%0d] got=%h want=%h", ops[k], i, obs, exp); end
      end
    end
  endtask

  task automatic test_random();
    logic [18:0] obs, exp;
    logic [6:0] legal [6];
    legal[0] = LOAD; legal[1] = STORE; legal[2] = OPIMM; legal[3] = OPR; legal[4] = BR; legal[5] = JAL;
    for (int n = 0; n < 40; n++) begin
      clear_q();
      build(legal[$urandom_range(0, 5)], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      for (int i = 0; i < st_q.size(); i++) begin
        step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
        exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rand%0d[%0d] got=%h want=%h", n, i, obs, exp); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] obs, exp;
    clear_q(); build(7'b1111111, 1'b0, 1, 0, 20);
    for (int i = 0; i < st_q.size(); i++) begin
      step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
      exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL illegal[%0d] got=%h want=%h", i, obs, exp); end
    end
    // leave ILLEGAL by reset, wait in FETCH, then reset again mid-wait
    exp = exp_vec(0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7'b1111111, obs);
    total++;
    if (obs[18:1] !== exp[18:1]) begin bad++; $display("FAIL ill_reset got=%h want=%h", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 7'($urandom), obs);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL fetch_wait[%0d] got=%h want=%h", i, obs, exp); end
    end
    step(1'b1, 1'b1, 1'b1, 7'($urandom), obs);
    total++;
    if (obs[18:1] !== exp[18:1]) begin bad++; $display("FAIL wait_reset got=%h want=%h", obs, exp); end
    clear_q(); build(LOAD, 1'b0, 2, 1, 0);
    for (int i = 0; i < st_q.size(); i++) begin
      step(1'b0, mr_q[i], z_q[i], op_q[i], obs);
      exp = exp_vec(st_q[i], mr_q[i], z_q[i]);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL recover[%0d] got=%h want=%h", i, obs, exp); end
    end
  endtask

  initial begin
    reset = 1'b1; ctl.mem_ready = 1'b0; ctl.zero = 1'b0; ctl.op = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_store_wait();
    test_branch();
    test_jal_exec();
    test_random();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
